// File: rtl/buf_wr_arbiter_if.sv
// DMA-side read streams (DAT and WT) feeding the buffer write arbiter.
// The arbiter uses the slave modport; the DMA read engines use master.
interface buf_wr_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DAT_W  = 256,
   parameter int unsigned WT_W   = 256
) ();
   logic              dat_valid;
   logic              dat_ready;
   logic              dat_last;
   logic [ADDR_W-1:0] dat_addr;
   logic [DAT_W-1:0]  dat_data;

   logic              wt_valid;
   logic              wt_ready;
   logic              wt_last;
   logic [ADDR_W-1:0] wt_addr;
   logic [WT_W-1:0]   wt_data;

   modport master (
      output dat_valid, dat_last, dat_addr, dat_data,
      output wt_valid, wt_last, wt_addr, wt_data,
      input  dat_ready, wt_ready
   );

   modport slave (
      input  dat_valid, dat_last, dat_addr, dat_data,
      input  wt_valid, wt_last, wt_addr, wt_data,
      output dat_ready, wt_ready
   );
endinterface

// File: rtl/buf_wr_arbiter.sv
// Burst-granular round-robin arbiter putting DAT and WT beats onto the
// convolution buffer's single write path, with bank-range error flag.
module buf_wr_arbiter #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned BANK_AW   = 12,
   parameter int unsigned BANK_NUM  = 8,
   parameter int unsigned DAT_W     = 256,
   parameter int unsigned WT_W      = 256,
   parameter int unsigned BURST_MAX = 16,
   parameter int unsigned HOLD_TO   = 16
) (
   input  logic              clk,
   input  logic              rst,
   buf_wr_arbiter_if.slave   rd_if,
   output logic              dma2buf_DAT_wr_en,
   output logic [ADDR_W-1:0] dma2buf_DAT_wr_addr,
   output logic [DAT_W-1:0]  dma2buf_DAT_wr_data,
   output logic              dma2buf_WT_wr_en,
   output logic [ADDR_W-1:0] dma2buf_WT_wr_addr,
   output logic [WT_W-1:0]   dma2buf_WT_wr_data,
   input  logic              err_clr,
   output logic              addr_err,
   output logic              busy
);

   localparam int unsigned BANK_W  = ADDR_W - BANK_AW;
   localparam int unsigned BEAT_W  = $clog2(BURST_MAX + 1);
   localparam int unsigned STALL_W = (HOLD_TO > 1) ? $clog2(HOLD_TO) : 1;
   localparam logic [BEAT_W-1:0]  BEAT_SAT  = BEAT_W'(BURST_MAX);
   localparam logic [STALL_W-1:0] STALL_SAT = STALL_W'(HOLD_TO - 1);
   localparam logic SIDE_DAT = 1'b0;
   localparam logic SIDE_WT  = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_DAT = 2'd1,
      GNT_WT  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                last_gnt_q, last_gnt_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic                dat_ready_q, dat_ready_d;
   logic                wt_ready_q, wt_ready_d;
   logic                busy_q, busy_d;
   logic                dat_wr_en_q, dat_wr_en_d;
   logic [ADDR_W-1:0]   dat_wr_addr_q, dat_wr_addr_d;
   logic [DAT_W-1:0]    dat_wr_data_q, dat_wr_data_d;
   logic                wt_wr_en_q, wt_wr_en_d;
   logic [ADDR_W-1:0]   wt_wr_addr_q, wt_wr_addr_d;
   logic [WT_W-1:0]     wt_wr_data_q, wt_wr_data_d;
   logic                addr_err_q, addr_err_d;

   logic                dat_acc;
   logic                wt_acc;
   logic [BEAT_W-1:0]   beat_inc;
   logic                burst_full;
   logic                go_dat;
   logic                go_wt;
   logic [BANK_W-1:0]   dat_bank;
   logic [BANK_W-1:0]   wt_bank;
   logic                bank_bad;

   // Ready is a pure state decode, so acceptance is ready(state) & valid.
   assign dat_acc    = (state_q == GNT_DAT) & rd_if.dat_valid;
   assign wt_acc     = (state_q == GNT_WT) & rd_if.wt_valid;
   assign beat_inc   = (beat_cnt_q == BEAT_SAT) ? beat_cnt_q : beat_cnt_q + BEAT_W'(1);
   assign burst_full = (beat_inc == BEAT_SAT);
   assign dat_bank   = rd_if.dat_addr[ADDR_W-1:BANK_AW];
   assign wt_bank    = rd_if.wt_addr[ADDR_W-1:BANK_AW];
   assign bank_bad   = (dat_acc & (32'(dat_bank) >= BANK_NUM)) |
                       (wt_acc & (32'(wt_bank) >= BANK_NUM));

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = stall_cnt_q;
      go_dat      = 1'b0;
      go_wt       = 1'b0;

      case (state_q)
         IDLE: begin
            if (rd_if.dat_valid && rd_if.wt_valid) begin
               go_dat = (last_gnt_q == SIDE_WT);
               go_wt  = (last_gnt_q == SIDE_DAT);
            end else begin
               go_dat = rd_if.dat_valid;
               go_wt  = rd_if.wt_valid;
            end
         end
         GNT_DAT: begin
            if (rd_if.dat_valid) begin
               beat_cnt_d  = beat_inc;
               stall_cnt_d = '0;
               if (rd_if.dat_last || (burst_full && rd_if.wt_valid)) begin
                  go_wt   = rd_if.wt_valid;
                  state_d = IDLE;
               end
            end else if (stall_cnt_q == STALL_SAT) begin
               go_wt = rd_if.wt_valid;
            end else begin
               stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
         end
         GNT_WT: begin
            if (rd_if.wt_valid) begin
               beat_cnt_d  = beat_inc;
               stall_cnt_d = '0;
               if (rd_if.wt_last || (burst_full && rd_if.dat_valid)) begin
                  go_dat  = rd_if.dat_valid;
                  state_d = IDLE;
               end
            end else if (stall_cnt_q == STALL_SAT) begin
               go_dat = rd_if.dat_valid;
            end else begin
               stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Grant entry overrides whatever the state branch decided.
      if (go_dat) begin
         state_d     = GNT_DAT;
         last_gnt_d  = SIDE_DAT;
         beat_cnt_d  = '0;
         stall_cnt_d = '0;
      end else if (go_wt) begin
         state_d     = GNT_WT;
         last_gnt_d  = SIDE_WT;
         beat_cnt_d  = '0;
         stall_cnt_d = '0;
      end

      dat_ready_d   = (state_d == GNT_DAT);
      wt_ready_d    = (state_d == GNT_WT);
      busy_d        = (state_d != IDLE);

      dat_wr_en_d   = dat_acc;
      dat_wr_addr_d = dat_acc ? rd_if.dat_addr : '0;
      dat_wr_data_d = dat_acc ? rd_if.dat_data : '0;
      wt_wr_en_d    = wt_acc;
      wt_wr_addr_d  = wt_acc ? rd_if.wt_addr : '0;
      wt_wr_data_d  = wt_acc ? rd_if.wt_data : '0;

      // A new bad beat wins over a simultaneous clear.
      addr_err_d = addr_err_q;
      if (err_clr)  addr_err_d = 1'b0;
      if (bank_bad) addr_err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         last_gnt_q    <= SIDE_WT;
         beat_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         dat_ready_q   <= 1'b0;
         wt_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         dat_wr_en_q   <= 1'b0;
         dat_wr_addr_q <= '0;
         dat_wr_data_q <= '0;
         wt_wr_en_q    <= 1'b0;
         wt_wr_addr_q  <= '0;
         wt_wr_data_q  <= '0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_gnt_q    <= last_gnt_d;
         beat_cnt_q    <= beat_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         dat_ready_q   <= dat_ready_d;
         wt_ready_q    <= wt_ready_d;
         busy_q        <= busy_d;
         dat_wr_en_q   <= dat_wr_en_d;
         dat_wr_addr_q <= dat_wr_addr_d;
         dat_wr_data_q <= dat_wr_data_d;
         wt_wr_en_q    <= wt_wr_en_d;
         wt_wr_addr_q  <= wt_wr_addr_d;
         wt_wr_data_q  <= wt_wr_data_d;
         addr_err_q    <= addr_err_d;
      end
   end

   assign rd_if.dat_ready     = dat_ready_q;
   assign rd_if.wt_ready      = wt_ready_q;
   assign busy                = busy_q;
   assign addr_err            = addr_err_q;
   assign dma2buf_DAT_wr_en   = dat_wr_en_q;
   assign dma2buf_DAT_wr_addr = dat_wr_addr_q;
   assign dma2buf_DAT_wr_data = dat_wr_data_q;
   assign dma2buf_WT_wr_en    = wt_wr_en_q;
   assign dma2buf_WT_wr_addr  = wt_wr_addr_q;
   assign dma2buf_WT_wr_data  = wt_wr_data_q;

endmodule
